// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings and state enum for the HI/LO multiply/divide unit
//
// Purpose: op codes driven by the Execute-stage controller, plus the
//          muldiv_hilo controller state encoding.
// Ports:   none (package)
package muldiv_pkg;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } md_state_t;

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_hilo_div_step.sv
// rtl/muldiv_hilo_div_step.sv - one combinational restoring-division iteration
//
// Purpose: shift the next dividend bit into the partial remainder, try to
//          subtract the divisor, and shift the resulting quotient bit in.
// Ports:   rem_in  [WIDTH:0]   partial remainder
//          quo_in  [WIDTH-1:0] dividend bits not yet consumed / quotient so far
//          dvs_in  [WIDTH-1:0] divisor magnitude
//          rem_out [WIDTH:0]   next partial remainder
//          quo_out [WIDTH-1:0] next quotient shift register
module div_restoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs_in,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  // The remainder is always below the divisor, so the shifted value fits in
  // WIDTH+1 bits and bit WIDTH of the difference is a clean borrow flag.
  assign w_shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, dvs_in};

  always_comb begin
    rem_out = w_shifted;
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (!w_diff[WIDTH]) begin
      rem_out = w_diff;
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - multi-cycle multiply/divide unit owning the HI/LO registers
//
// Purpose: executes MULT/MULTU (pipelined), DIV/DIVU (iterative restoring),
//          MTHI/MTLO (single cycle); reports busy/stall to the hazard unit.
// Ports:   clk, reset (sync, active-high)
//          start, op[2:0], srca, srcb   Execute-stage request and operands
//          flush                        cancels in-flight op / blocks accept
//          hilo_rd                      Decode holds mfhi/mflo
//          hi, lo                       committed HI/LO
//          busy, stall, done            status to hazard unit / pipeline
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + MUL_STAGES + 1);

  md_state_t              r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_hi, r_lo;
  logic                   r_done;
  logic [2*WIDTH-1:0]     r_pipe [MUL_STAGES];
  logic [WIDTH:0]         r_rem;
  logic [WIDTH-1:0]       r_quo, r_dvs;
  logic                   r_qneg, r_rneg, r_dz;

  logic                   w_accept, w_sgn, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]       w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0]     w_ax, w_bx, w_prod;
  logic [WIDTH:0]         w_rem_nxt;
  logic [WIDTH-1:0]       w_quo_nxt, w_q_fix, w_r_fix;
  logic                   w_commit_mul, w_commit_div;

  assign w_accept = (r_state == S_IDLE) && start && !flush && (op != MD_NOP) && (op != 3'd7);
  assign w_sgn    = md_is_signed(op);
  assign w_a_neg  = w_sgn & srca[WIDTH-1];
  assign w_b_neg  = w_sgn & srcb[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -srca : srca;
  assign w_b_mag  = w_b_neg ? -srcb : srcb;

  // Sign-extending to 2*WIDTH and keeping the low 2*WIDTH bits of the
  // product gives the exact signed or unsigned result.
  assign w_ax   = {{WIDTH{w_a_neg}}, srca};
  assign w_bx   = {{WIDTH{w_b_neg}}, srcb};
  assign w_prod = w_ax * w_bx;

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (r_rem),
    .quo_in  (r_quo),
    .dvs_in  (r_dvs),
    .rem_out (w_rem_nxt),
    .quo_out (w_quo_nxt)
  );

  assign w_q_fix = r_qneg ? -r_quo : r_quo;
  assign w_r_fix = r_rneg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_commit_mul = 1'b0;
    w_commit_div = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (op == MD_MULT || op == MD_MULTU)) w_state_nxt = S_MUL;
        else if (w_accept && (op == MD_DIV || op == MD_DIVU)) w_state_nxt = S_DIV;
      end
      S_MUL: begin
        if (r_cnt == '0) begin
          w_state_nxt  = S_IDLE;
          w_commit_mul = 1'b1;
        end
      end
      S_DIV: begin
        if (r_cnt == '0) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_state_nxt  = S_IDLE;
        w_commit_div = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A flush also kills the completing edge, so HI/LO never see the result.
    if (flush) begin
      w_state_nxt  = S_IDLE;
      w_commit_mul = 1'b0;
      w_commit_div = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
      for (int k = 0; k < MUL_STAGES; k++) r_pipe[k] <= '0;
    end else begin
      r_done <= w_commit_mul | w_commit_div;
      for (int k = 1; k < MUL_STAGES; k++) r_pipe[k] <= r_pipe[k-1];
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op)
              MD_MTHI: r_hi <= srca;
              MD_MTLO: r_lo <= srca;
              MD_MULT, MD_MULTU: begin
                r_pipe[0] <= w_prod;
                r_cnt     <= CW'(MUL_STAGES - 1);
              end
              MD_DIV, MD_DIVU: begin
                r_rem  <= '0;
                r_quo  <= w_a_mag;
                r_dvs  <= w_b_mag;
                r_qneg <= w_a_neg ^ w_b_neg;
                r_rneg <= w_a_neg;
                r_dz   <= (srcb == '0);
                r_cnt  <= CW'(WIDTH - 1);
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
      if (w_commit_mul) {r_hi, r_lo} <= r_pipe[MUL_STAGES-1];
      if (w_commit_div) begin
        // Divide by zero leaves the unsigned all-ones quotient regardless of sign.
        r_lo <= r_dz ? '1 : w_q_fix;
        r_hi <= w_r_fix;
      end
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = (r_state != S_IDLE);
  assign stall = busy & (start | hilo_rd);
  assign done  = r_done;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - self-checking bench for muldiv_hilo (32-bit and 8-bit instances)
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, flush, hilo_rd;
  logic [2:0]  op;
  logic [31:0] srca, srcb, hi, lo;
  logic        busy, stall, done;

  logic        reset8, start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, stall8, done8;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_q[$];
  logic [63:0] saved;

  muldiv_hilo #(.WIDTH(32), .MUL_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .hilo_rd(hilo_rd), .hi(hi), .lo(lo), .busy(busy),
    .stall(stall), .done(done)
  );

  muldiv_hilo #(.WIDTH(8), .MUL_STAGES(1)) u_dut8 (
    .clk(clk), .reset(reset8), .start(start8), .op(op8), .srca(a8), .srcb(b8),
    .flush(1'b0), .hilo_rd(1'b0), .hi(hi8), .lo(lo8), .busy(busy8),
    .stall(stall8), .done(done8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input bit sel, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int exp_busy);
    int nb;
    int cyc;
    logic [63:0] got;
    sb_q.push_back(exp);
    @(negedge clk);
    if (sel) begin start8 = 1'b1; op8 = o; a8 = a[7:0]; b8 = b[7:0]; end
    else     begin start  = 1'b1; op  = o; srca = a;    srcb = b;    end
    @(negedge clk);
    start = 1'b0; start8 = 1'b0;
    nb = 0; cyc = 0;
    while (!(sel ? done8 : done) && cyc < 100) begin
      if (sel ? busy8 : busy) nb++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_busy"}, 64'(nb), 64'(exp_busy));
    got = sel ? {48'h0, hi8, lo8} : {hi, lo};
    check({tag, "_hilo"}, got, sb_q.pop_front());
    @(negedge clk);
    check({tag, "_done_once"}, 64'(sel ? done8 : done), 64'd0);
  endtask

  initial begin
    int nb, bad, cyc, ndone;
    reset = 1'b1; start = 1'b0; op = MD_NOP; srca = '0; srcb = '0;
    flush = 1'b0; hilo_rd = 1'b0;
    reset8 = 1'b1; start8 = 1'b0; op8 = MD_NOP; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0; reset8 = 1'b0;
    check("reset_state", {hi, lo}, 64'h0);
    check("reset_status", {61'h0, busy, done, stall}, 64'h0);
    check("reset_state8", {46'h0, hi8, lo8, busy8, done8}, 64'h0);

    // MTHI then MTLO back to back
    @(negedge clk); start = 1'b1; op = MD_MTHI; srca = 32'h12345678;
    @(negedge clk);
    check("mthi", 64'(hi), 64'h12345678);
    check("mthi_busy", 64'(busy), 64'd0);
    op = MD_MTLO; srca = 32'h9ABCDEF0;
    @(negedge clk); start = 1'b0;
    check("mtlo", {hi, lo}, 64'h12345678_9ABCDEF0);
    check("mtlo_busy", {62'h0, busy, done}, 64'd0);

    // flush alongside start in IDLE blocks even MTHI
    @(negedge clk); start = 1'b1; op = MD_MTHI; srca = 32'hDEADBEEF; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    check("flush_idle_mthi", 64'(hi), 64'h12345678);

    do_op("mult",   1'b0, MD_MULT,  32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 2);
    do_op("multu",  1'b0, MD_MULTU, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA, 2);
    do_op("div",    1'b0, MD_DIV,   32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    do_op("divu",   1'b0, MD_DIVU,  32'd100,      32'd7, 64'h00000002_0000000E, 33);
    do_op("divu0",  1'b0, MD_DIVU,  32'h55,       32'd0, 64'h00000055_FFFFFFFF, 33);
    do_op("divovf", 1'b0, MD_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    do_op("div_mix", 1'b0, MD_DIV,  32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);

    // hilo_rd held through a divide: stall on every busy cycle, not in done cycle
    sb_q.push_back(64'h00000000_00000064);
    @(negedge clk); start = 1'b1; op = MD_DIVU; srca = 32'd1000; srcb = 32'd10;
    @(negedge clk); start = 1'b0; hilo_rd = 1'b1;
    nb = 0; bad = 0; cyc = 0;
    while (!done && cyc < 100) begin
      if (busy) begin nb++; if (!stall) bad++; end
      @(negedge clk);
      cyc++;
    end
    check("hilord_stall_busy", 64'(bad), 64'd0);
    check("hilord_nbusy", 64'(nb), 64'd33);
    check("hilord_stall_done", 64'(stall), 64'd0);
    check("hilord_hilo", {hi, lo}, sb_q.pop_front());
    hilo_rd = 1'b0;

    // MULT issued mid-divide is ignored
    sb_q.push_back(64'h00000000_0000000A);
    @(negedge clk); start = 1'b1; op = MD_DIVU; srca = 32'd50; srcb = 32'd5;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = MD_MULT; srca = 32'd3; srcb = 32'd3;
    #1 check("midmul_stall", 64'(stall), 64'd1);
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("midmul_ndone", 64'(ndone), 64'd1);
    check("midmul_hilo", {hi, lo}, sb_q.pop_front());

    // flush at busy cycle 10 of a divide
    saved = {hi, lo};
    @(negedge clk); start = 1'b1; op = MD_DIV; srca = 32'd1234; srcb = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("flush_busy_drop", 64'(busy), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(ndone), 64'd0);
    check("flush_hilo", {hi, lo}, saved);

    // reset in the middle of a divide
    do_op("pre_rst", 1'b0, MD_MULTU, 32'h10000, 32'h10001, 64'h00000001_00010000, 2);
    @(negedge clk); start = 1'b1; op = MD_DIV; srca = 32'hFFFFFFF9; srcb = 32'd2;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midrst_busy", {62'h0, busy, done}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'h0);

    // narrow instance
    do_op("mult8", 1'b1, MD_MULT, 32'h80, 32'h80, 64'h4000, 1);
    do_op("multu8", 1'b1, MD_MULTU, 32'hFF, 32'hFF, 64'hFE01, 1);
    do_op("div8",  1'b1, MD_DIV,  32'hF9, 32'h02, 64'hFFFD, 9);
    do_op("divovf8", 1'b1, MD_DIV, 32'h80, 32'hFF, 64'h0080, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO architectural registers. It fills the role behind the pipeline's hilowrite path.
- Sits beside the Execute-stage ALU and receives operands after forwarding.
- Reports busy/stall to the hazard unit so that later mul/div ops and mfhi/mflo reads wait for completion.
- Generalises the fixed 32-bit HI/LO write with:
  - configurable operand width and multiply latency;
  - signed and unsigned modes;
  - iterative divide;
  - pipeline-flush cancellation.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits; must be at least 4.
- MUL_STAGES, 2, cycles from multiply accept to HI/LO update; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  Execute-stage op valid this cycle.
- op  in  3  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
- srca  in  WIDTH  forwarded rs operand; dividend or multiplicand; source for MTHI/MTLO.
- srcb  in  WIDTH  forwarded rt operand; divisor or multiplier.
- flush  in  1  cancels any in-flight op.
- hilo_rd  in  1  Decode stage holds mfhi/mflo.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  a multiply or divide is in flight.
- stall  out  1  request to the hazard unit to stall F and D and flush E.
- done  out  1  one-cycle pulse in the cycle after HI/LO is written by a multiply or divide.

Behaviour:
- Reset: hi=0, lo=0, state IDLE, busy=0, done=0, internal counters 0. Reset mid-operation abandons the op; HI/LO end at 0.
- State machine: IDLE, MUL, DIV, FIX. busy = (state != IDLE). busy is registered.
- Accept rule: the op is taken at edge E0 when state==IDLE, start=1, flush=0 and op is 1..6.
  - start while busy is ignored; hazard stalling keeps it from being lost.
  - Op codes 0 and 7 are ignored.
- MTHI/MTLO: at edge E0, hi<=srca (or lo<=srca). No busy, no done.
- MULT/MULTU: operands are latched at E0; state goes to MUL.
  - {hi,lo} <= the full 2*WIDTH-bit product at edge E0+MUL_STAGES.
  - MULT is two's-complement signed; MULTU is unsigned.
  - State returns to IDLE; done=1 for exactly the next cycle.
  - busy is high for MUL_STAGES cycles.
- DIV/DIVU: restoring division on operand magnitudes. One quotient bit per cycle in state DIV, edges E0+1..E0+WIDTH, counter WIDTH-1 down to 0.
  - FIX state applies signs:
    - quotient is negative iff the operand signs differ;
    - remainder takes the dividend's sign.
  - lo<=quotient and hi<=remainder at edge E0+WIDTH+1; then IDLE and the done pulse.
  - busy is high for WIDTH+1 cycles.
  - Divisor 0: lo=all ones, hi=dividend. Latency is the same; no exception.
  - Signed most-negative / -1: lo=most-negative, hi=0.
- stall = busy & (start | hilo_rd). This is combinational and depends only on busy and the inputs.
- hi/lo always show committed values. Intermediate results never appear on hi/lo.
- flush:
  - With busy=1: state goes to IDLE at the next edge, HI/LO are unchanged, no done.
  - Together with start in IDLE: the op is not accepted, MTHI/MTLO included.
  - On the completing edge: the write is suppressed.
- Width rules:
  - Product is 2*WIDTH bits with no truncation.
  - Divider partial remainder is WIDTH+1 bits.
  - Magnitudes of operands and results are taken modulo 2^WIDTH.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encoding constants MD_NOP..MD_MTLO;
  - state enum constants S_IDLE, S_MUL, S_DIV, S_FIX.
- These constants are also used by the controller that generates op.
- One sub-module, div_restoring_step: combinational single-iteration restoring step.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next remainder, next quotient.
  - Instantiated once and reused each cycle.
- Multiply is inferred and followed by a MUL_STAGES-deep register chain.

Test Plan:
- Reset, then MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> hi=0x12345678 and lo=0x9ABCDEF0 one edge after each; busy is never high.
- MULT srca=0xFFFFFFFE (-2), srcb=3 -> busy for 2 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV srca=-7 (0xFFFFFFF9), srcb=2 -> busy 33 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- Boundary divides:
  - DIVU by 0, dividend 0x55 -> lo=0xFFFFFFFF, hi=0x55.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Hazard and flush:
  - During a DIV, assert hilo_rd -> stall=1 every busy cycle; stall=0 in the done cycle.
  - Issue MULT mid-DIV -> ignored; hi/lo reflect only the DIV.
  - flush at cycle 10 of a DIV -> busy drops next cycle; hi/lo unchanged; no done.
- Reset asserted mid-DIV -> next edge: busy=0, hi=lo=0. Then run with WIDTH=8, MUL_STAGES=1: MULT 0x80*0x80 -> {hi,lo}=0x4000; DIV busy 9 cycles.
